// File: rtl/alu_share_arbiter.sv
// Purpose: shares one registered ALU between two requesters (0 = execute, 1 = AGU/aux) round-robin.
// Latency: request accepted at edge N, alu_en high in cycle N+1, response valid from cycle N+3.
// Backpressure: req_ready only in IDLE; the response is held stable until the owner's resp_ready.
//
// Ports:
//   clk, rst (async, active-low), flush (synchronous abort of any in-flight operation)
//   req_valid/req_ready      per-requester request handshake; reqN_alucode/op1/op2 payload
//   resp_valid/resp_ready    per-requester response handshake; resp_result/br_taken/id payload
//   alu_en/alu_code/alu_op1/alu_op2 drive the ALU; alu_result/alu_br_taken come back from it
//   busy                     high whenever an operation is in flight
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CODE_W-1:0] req0_alucode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [CODE_W-1:0] req1_alucode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_br_taken,
  output logic              resp_id,
  output logic              alu_en,
  output logic [CODE_W-1:0] alu_code,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_br_taken,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                br_q, br_d;
  logic                id_q, id_d;

  logic                grant;
  logic                accept;

  // Single requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    grant     = (&req_valid) ? ~last_grant_q : req_valid[1];
    req_ready = 2'b00;
    if (state_q == IDLE && !flush && (|req_valid)) begin
      req_ready[grant] = 1'b1;
    end
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    code_d       = code_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    res_d        = res_q;
    br_d         = br_q;
    id_d         = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ISSUE;
          owner_d      = grant;
          last_grant_d = grant;
          code_d       = grant ? req1_alucode : req0_alucode;
          op1_d        = grant ? req1_op1     : req0_op1;
          op2_d        = grant ? req1_op2     : req0_op2;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // ALU output register was loaded at the end of ISSUE; sample it now.
        state_d = RESP;
        res_d   = alu_result;
        br_d    = alu_br_taken;
        id_d    = owner_q;
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a coincident response handshake.
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
      br_d    = br_q;
      id_d    = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      code_q       <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      code_q       <= code_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      res_q        <= res_d;
      br_q         <= br_d;
      id_q         <= id_d;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (state_q == RESP) resp_valid[owner_q] = 1'b1;
  end

  assign alu_en        = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign alu_code      = code_q;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign resp_result   = res_q;
  assign resp_br_taken = br_q;
  assign resp_id       = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 6;

  localparam logic [CW-1:0] ALU_ADD = 6'd0;
  localparam logic [CW-1:0] ALU_SUB = 6'd1;
  localparam logic [CW-1:0] ALU_AND = 6'd2;
  localparam logic [CW-1:0] ALU_OR  = 6'd3;
  localparam logic [CW-1:0] ALU_XOR = 6'd4;
  localparam logic [CW-1:0] ALU_BEQ = 6'd5;
  localparam logic [CW-1:0] ALU_BNE = 6'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [CW-1:0] req0_alucode, req1_alucode, alu_code;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [DW-1:0] resp_result, alu_op1, alu_op2;
  logic          resp_br_taken, resp_id, alu_en, busy;
  logic [DW-1:0] alu_result = '0;
  logic          alu_br_taken = 1'b0;

  alu_share_arbiter #(.DATA_W(DW), .CODE_W(CW)) dut (
    .clk(clk), .rst(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_alucode(req0_alucode), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_alucode(req1_alucode), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_br_taken(resp_br_taken), .resp_id(resp_id),
    .alu_en(alu_en), .alu_code(alu_code), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_br_taken(alu_br_taken), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU semantics: {br_taken, result}.
  function automatic logic [DW:0] alu_f(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      ALU_ADD: return {1'b0, a + b};
      ALU_SUB: return {1'b0, a - b};
      ALU_AND: return {1'b0, a & b};
      ALU_OR:  return {1'b0, a | b};
      ALU_XOR: return {1'b0, a ^ b};
      ALU_BEQ: return {(a == b), {DW{1'b0}}};
      ALU_BNE: return {(a != b), {DW{1'b0}}};
      default: return '0;
    endcase
  endfunction

  // Registered ALU stand-in.
  always @(posedge clk) begin
    if (alu_en) {alu_br_taken, alu_result} <= alu_f(alu_code, alu_op1, alu_op2);
  end

  // Transaction-level model: one op in flight, m_t counts cycles since acceptance.
  bit            m_busy, m_owner, m_last, m_br, m_id, m_g;
  int            m_t, m_done;
  logic [CW-1:0] m_code;
  logic [DW-1:0] m_op1, m_op2, m_res;
  logic [DW:0]   m_pending;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_t = 0; m_owner = 0; m_last = 1; m_br = 0; m_id = 0;
      m_code = '0; m_op1 = '0; m_op2 = '0; m_res = '0;
    end else if (flush) begin
      m_busy = 0; m_t = 0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_g       = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_busy    = 1; m_t = 1; m_owner = m_g; m_last = m_g;
        m_code    = m_g ? req1_alucode : req0_alucode;
        m_op1     = m_g ? req1_op1 : req0_op1;
        m_op2     = m_g ? req1_op2 : req0_op2;
        m_pending = alu_f(m_code, m_op1, m_op2);
      end
    end else begin
      if (m_t == 2) begin
        {m_br, m_res} = m_pending;
        m_id = m_owner;
      end
      if (m_t >= 3 && resp_ready[m_owner]) begin
        m_busy = 0; m_done++;
      end else begin
        m_t++;
      end
    end
  end

  bit       cmp_en = 0;
  bit       exp_g;
  logic [1:0] exp_ready, exp_rv;

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      exp_g     = (req_valid == 2'b11) ? !m_last : req_valid[1];
      exp_ready = (!m_busy && !flush && req_valid != 2'b00) ? (exp_g ? 2'b10 : 2'b01) : 2'b00;
      exp_rv    = (m_busy && m_t >= 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready",  64'(req_ready), 64'(exp_ready));
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      chk("resp_onehot", 64'($countones(resp_valid) <= 1), 64'(1));
      chk("alu_en",     64'(alu_en), 64'(m_busy && m_t == 1));
      chk("busy",       64'(busy), 64'(m_busy));
      chk("alu_code",   64'(alu_code), 64'(m_code));
      chk("alu_op1",    64'(alu_op1), 64'(m_op1));
      chk("alu_op2",    64'(alu_op2), 64'(m_op2));
      chk("resp_result", 64'(resp_result), 64'(m_res));
      chk("resp_br",    64'(resp_br_taken), 64'(m_br));
      chk("resp_id",    64'(resp_id), 64'(m_id));
    end
  end

  task automatic drive_req(input bit id, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id) begin req1_alucode = c; req1_op1 = a; req1_op2 = b; end
    else    begin req0_alucode = c; req0_op1 = a; req0_op2 = b; end
  endtask

  // One isolated op with hand-computed expectations; resp_ready must be high for id.
  task automatic single_op(input bit id, input logic [CW-1:0] c, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] er, input bit ebr);
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    @(negedge clk);
    drive_req(id, c, a, b);
    req_valid = oh;
    #1 chk("op_accept_ready", 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("op_en_n1", 64'(alu_en), 64'(1));
    @(negedge clk);
    #1 chk("op_en_n2", 64'(alu_en), 64'(0));
    chk("op_rv_n2", 64'(resp_valid), 64'(0));
    @(negedge clk);
    #1 chk("op_rv_n3", 64'(resp_valid), 64'(oh));
    chk("op_result", 64'(resp_result), 64'(er));
    chk("op_br", 64'(resp_br_taken), 64'(ebr));
    chk("op_id", 64'(resp_id), 64'(id));
    @(negedge clk);
    #1 chk("op_idle_after", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit grants[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    drive_req(0, '0, '0, '0);
    drive_req(1, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1;
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_alu_op1", 64'(alu_op1), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    rst_n = 1'b1;

    // Single op and branch ops.
    single_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    single_op(1, ALU_BEQ, 32'd3, 32'd3, 32'd0, 1'b1);
    single_op(1, ALU_BEQ, 32'd3, 32'd4, 32'd0, 1'b0);

    // Contention from reset: grants must alternate starting with 0.
    do_reset();
    drive_req(0, ALU_SUB, 32'd10, 32'd3);
    drive_req(1, ALU_SUB, 32'd10, 32'd3);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    grants.delete();
    for (int i = 0; i < 24; i++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) grants.push_back(req_ready[1]);
      if ((resp_valid & resp_ready) != 2'b00) chk("cont_result", 64'(resp_result), 64'(7));
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("cont_grant_count", 64'(grants.size() >= 5), 64'(1));
    foreach (grants[i]) chk("cont_grant_order", 64'(grants[i]), 64'(i % 2));
    repeat (5) @(negedge clk);

    // Backpressure on requester 0 while requester 1 keeps asking.
    resp_ready = 2'b10;
    drive_req(0, ALU_ADD, 32'd100, 32'd23);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_rv", 64'(resp_valid), 64'(2'b01));
      chk("bp_result", 64'(resp_result), 64'(123));
      chk("bp_id", 64'(resp_id), 64'(0));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    @(negedge clk);
    resp_ready = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    resp_ready = 2'b11;
    #1 chk("bp_done_busy", 64'(busy), 64'(0));
    chk("bp_done_rv", 64'(resp_valid), 64'(0));

    // Flush in WAIT: nothing comes back, next op is normal.
    @(negedge clk);
    drive_req(0, ALU_SUB, 32'd50, 32'd8);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flw_busy_before", 64'(busy), 64'(1));
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("flw_no_resp", 64'(resp_valid), 64'(0));
      chk("flw_idle", 64'(busy), 64'(0));
      @(negedge clk);
    end
    single_op(0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0);

    // Flush coinciding with the response handshake: dropped.
    @(negedge clk);
    drive_req(1, ALU_AND, 32'hF0, 32'h3C);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flr_rv_before", 64'(resp_valid), 64'(2'b10));
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flr_rv_after", 64'(resp_valid), 64'(0));
    chk("flr_busy_after", 64'(busy), 64'(0));
    single_op(1, ALU_XOR, 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0);

    // Asynchronous reset between edges while in ISSUE.
    @(negedge clk);
    drive_req(0, ALU_ADD, 32'd9, 32'd9);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #2 chk("ar_in_issue", 64'(alu_en), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_alu_en", 64'(alu_en), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_code", 64'(alu_code), 64'(0));
    chk("ar_op1", 64'(alu_op1), 64'(0));
    chk("ar_op2", 64'(alu_op2), 64'(0));
    chk("ar_result", 64'(resp_result), 64'(0));
    chk("ar_rv", 64'(resp_valid), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, ALU_OR, 32'h1, 32'h2);
    drive_req(1, ALU_OR, 32'h4, 32'h8);
    req_valid = 2'b11;
    #1 chk("ar_first_tie", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < 2; r++) begin
        logic [DW-1:0] a, b;
        a = DW'($urandom_range(0, 15));
        b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        drive_req(r[0], CW'($urandom_range(0, 6)), a, b);
      end
      @(negedge clk);
    end
    flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    repeat (6) @(negedge clk);
    chk("rand_completed_ops", 64'(m_done > 10), 64'(1));

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
